// File: rtl/pong_pkg.sv
// Shared types and default tone constants for the Pong sound-effect generator.
package pong_pkg;

  // Numeric order is the event priority
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    WALL   = 2'd1,
    PADDLE = 2'd2,
    SCORE  = 2'd3
  } tone_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int unsigned DEF_PADDLE_HALF = 145;
  localparam int unsigned DEF_WALL_HALF   = 281;
  localparam int unsigned DEF_SCORE_HALF  = 97;
  localparam int unsigned DEF_PADDLE_LEN  = 12800;
  localparam int unsigned DEF_WALL_LEN    = 6400;
  localparam int unsigned DEF_SCORE_LEN   = 64000;
  localparam int unsigned DEF_HALF_W      = 12;
  localparam int unsigned DEF_LEN_W       = 20;

  // Highest-priority tone among the asserted events, NONE if none.
  function automatic tone_t pick_tone(input logic score, input logic paddle, input logic wall);
    tone_t t;
    t = NONE;
    if (score)       t = SCORE;
    else if (paddle) t = PADDLE;
    else if (wall)   t = WALL;
    return t;
  endfunction

endpackage

// File: rtl/pong_tone_gen_tick_edge_detect.sv
// Rising-edge pulse from a slow signal sampled as data; the previous value
// resets high so a signal that powers up high yields no spurious pulse.
module tick_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic rise_pulse
);

  logic prev_value;

  always_ff @(posedge clk_in) begin
    if (rst) prev_value <= 1'b1;
    else     prev_value <= sig_in;
  end

  assign rise_pulse = sig_in & ~prev_value;

endmodule

// File: rtl/pong_tone_gen.sv
// Turns paddle/wall/score events into fixed-length square-wave beeps timed
// by rising edges of the divided clock.
module pong_tone_gen
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_HALF = DEF_PADDLE_HALF,
  parameter int unsigned WALL_HALF   = DEF_WALL_HALF,
  parameter int unsigned SCORE_HALF  = DEF_SCORE_HALF,
  parameter int unsigned PADDLE_LEN  = DEF_PADDLE_LEN,
  parameter int unsigned WALL_LEN    = DEF_WALL_LEN,
  parameter int unsigned SCORE_LEN   = DEF_SCORE_LEN,
  parameter int unsigned HALF_W      = DEF_HALF_W,
  parameter int unsigned LEN_W       = DEF_LEN_W
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_src,
  input  logic evt_paddle,
  input  logic evt_wall,
  input  logic evt_score,
  input  logic mute,
  output logic audio_out,
  output logic busy
);

  if (PADDLE_HALF < 1 || WALL_HALF < 1 || SCORE_HALF < 1 ||
      PADDLE_LEN < 1 || WALL_LEN < 1 || SCORE_LEN < 1) begin : g_bad_min
    $error("pong_tone_gen: every HALF and LEN must be at least 1");
  end
  if (64'(PADDLE_HALF) >= (64'd1 << HALF_W) || 64'(WALL_HALF) >= (64'd1 << HALF_W) ||
      64'(SCORE_HALF) >= (64'd1 << HALF_W) || 64'(PADDLE_LEN) >= (64'd1 << LEN_W) ||
      64'(WALL_LEN) >= (64'd1 << LEN_W) || 64'(SCORE_LEN) >= (64'd1 << LEN_W)) begin : g_bad_width
    $error("pong_tone_gen: HALF or LEN does not fit its counter width");
  end

  logic tick;

  tick_edge_detect u_tick (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (tick_src),
    .rise_pulse (tick)
  );

  state_t            state,      state_nxt;
  tone_t             cur_tone,   tone_nxt;
  logic [HALF_W-1:0] half_sel,   half_sel_nxt;
  logic [LEN_W-1:0]  len_sel,    len_sel_nxt;
  logic [HALF_W-1:0] half_cnt,   half_cnt_nxt;
  logic [LEN_W-1:0]  len_cnt,    len_cnt_nxt;
  logic              tone_level, level_nxt;
  logic              audio_nxt,  busy_nxt;

  tone_t             evt_tone;
  logic              restart;
  logic [HALF_W-1:0] evt_half;
  logic [LEN_W-1:0]  evt_len;

  assign evt_tone = pick_tone(evt_score, evt_paddle, evt_wall);
  // In IDLE cur_tone is NONE, so any event qualifies
  assign restart  = (evt_tone != NONE) && (evt_tone >= cur_tone);

  always_comb begin
    evt_half = HALF_W'(WALL_HALF);
    evt_len  = LEN_W'(WALL_LEN);
    case (evt_tone)
      SCORE: begin
        evt_half = HALF_W'(SCORE_HALF);
        evt_len  = LEN_W'(SCORE_LEN);
      end
      PADDLE: begin
        evt_half = HALF_W'(PADDLE_HALF);
        evt_len  = LEN_W'(PADDLE_LEN);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    tone_nxt     = cur_tone;
    half_sel_nxt = half_sel;
    len_sel_nxt  = len_sel;
    half_cnt_nxt = half_cnt;
    len_cnt_nxt  = len_cnt;
    level_nxt    = tone_level;

    if (restart) begin
      state_nxt    = PLAY;
      tone_nxt     = evt_tone;
      half_sel_nxt = evt_half;
      len_sel_nxt  = evt_len;
      half_cnt_nxt = '0;
      len_cnt_nxt  = '0;
      level_nxt    = 1'b1;
    end else if (state == PLAY && tick) begin
      // End of beep takes precedence over a toggle on the same tick
      if (len_cnt == len_sel - LEN_W'(1)) begin
        state_nxt    = IDLE;
        tone_nxt     = NONE;
        half_cnt_nxt = '0;
        len_cnt_nxt  = '0;
        level_nxt    = 1'b0;
      end else begin
        len_cnt_nxt = len_cnt + LEN_W'(1);
        if (half_cnt == half_sel - HALF_W'(1)) begin
          half_cnt_nxt = '0;
          level_nxt    = ~tone_level;
        end else begin
          half_cnt_nxt = half_cnt + HALF_W'(1);
        end
      end
    end

    audio_nxt = level_nxt & ~mute & (state_nxt == PLAY);
    busy_nxt  = (state_nxt == PLAY);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      cur_tone   <= NONE;
      half_sel   <= '0;
      len_sel    <= '0;
      half_cnt   <= '0;
      len_cnt    <= '0;
      tone_level <= 1'b0;
      audio_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_tone   <= tone_nxt;
      half_sel   <= half_sel_nxt;
      len_sel    <= len_sel_nxt;
      half_cnt   <= half_cnt_nxt;
      len_cnt    <= len_cnt_nxt;
      tone_level <= level_nxt;
      audio_out  <= audio_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pong_tone_gen.sv
// Directed bench for pong_tone_gen with shortened tones so whole beeps fit in a few ticks.
module tb_pong_tone_gen;
  import pong_pkg::*;

  logic clk_in = 1'b0;
  logic rst, tick_src, evt_paddle, evt_wall, evt_score, mute;
  logic audio_out, busy;

  int checks = 0;
  int errors = 0;
  logic exp_audio [8];

  pong_tone_gen #(
    .PADDLE_HALF (2),
    .PADDLE_LEN  (8),
    .WALL_HALF   (3),
    .WALL_LEN    (8),
    .SCORE_HALF  (3),
    .SCORE_LEN   (10),
    .HALF_W      (12),
    .LEN_W       (20)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_src   (tick_src),
    .evt_paddle (evt_paddle),
    .evt_wall   (evt_wall),
    .evt_score  (evt_score),
    .mute       (mute),
    .audio_out  (audio_out),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // One divided-clock period: low for a cycle, then the rising edge is sampled.
  task automatic do_tick();
    tick_src = 1'b0;
    cyc();
    tick_src = 1'b1;
    cyc();
  endtask

  initial begin
    exp_audio[0] = 1'b1; exp_audio[1] = 1'b0; exp_audio[2] = 1'b0; exp_audio[3] = 1'b1;
    exp_audio[4] = 1'b1; exp_audio[5] = 1'b0; exp_audio[6] = 1'b0; exp_audio[7] = 1'b0;

    rst = 1'b1; tick_src = 1'b1;
    evt_paddle = 1'b0; evt_wall = 1'b0; evt_score = 1'b0; mute = 1'b0;
    cyc(); cyc();
    check("reset_audio", 32'(audio_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    check("reset_tone", 32'(dut.cur_tone), 32'(NONE));
    rst = 1'b0;

    // Tick extraction
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("tick_held_high", 32'(dut.tick), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      tick_src = 1'b0;
      cyc();
      check("tick_low", 32'(dut.tick), 32'd0);
      cyc();
      tick_src = 1'b1;
      #1;
      check("tick_rise", 32'(dut.tick), 32'd1);
      cyc();
      check("tick_one_cycle", 32'(dut.tick), 32'd0);
    end

    // Paddle beep
    evt_paddle = 1'b1;
    cyc();
    evt_paddle = 1'b0;
    check("paddle_start_busy", 32'(busy), 32'd1);
    check("paddle_start_audio", 32'(audio_out), 32'd1);
    repeat (5) cyc();
    check("paddle_hold_no_tick", 32'(audio_out), 32'd1);
    for (int i = 0; i < 8; i++) begin
      do_tick();
      check($sformatf("paddle_audio_t%0d", i + 1), 32'(audio_out), 32'(exp_audio[i]));
      check($sformatf("paddle_busy_t%0d", i + 1), 32'(busy), (i < 7) ? 32'd1 : 32'd0);
    end
    check("paddle_end_state", 32'(dut.state), 32'(IDLE));

    // Wall, then higher-priority paddle restarts, lower wall ignored
    evt_wall = 1'b1;
    cyc();
    evt_wall = 1'b0;
    check("wall_tone", 32'(dut.cur_tone), 32'(WALL));
    check("wall_busy", 32'(busy), 32'd1);
    do_tick();
    evt_paddle = 1'b1;
    cyc();
    evt_paddle = 1'b0;
    check("wall_to_paddle", 32'(dut.cur_tone), 32'(PADDLE));
    check("wall_to_paddle_len", 32'(dut.len_cnt), 32'd0);
    evt_wall = 1'b1;
    cyc();
    evt_wall = 1'b0;
    check("paddle_ignores_wall", 32'(dut.cur_tone), 32'(PADDLE));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_clears_busy", 32'(busy), 32'd0);

    // Priority: wall+score together picks score
    evt_wall = 1'b1; evt_score = 1'b1;
    cyc();
    evt_wall = 1'b0; evt_score = 1'b0;
    check("prio_tone", 32'(dut.cur_tone), 32'(SCORE));
    check("prio_audio", 32'(audio_out), 32'd1);
    do_tick(); do_tick();
    evt_wall = 1'b1;
    cyc();
    evt_wall = 1'b0;
    check("score_ignores_wall_tone", 32'(dut.cur_tone), 32'(SCORE));
    check("score_ignores_wall_len", 32'(dut.len_cnt), 32'd2);
    do_tick(); do_tick();
    check("score_t4_audio", 32'(audio_out), 32'd0);
    check("score_t4_len", 32'(dut.len_cnt), 32'd4);
    // Retrigger on the same cycle as tick 5
    tick_src = 1'b0;
    cyc();
    tick_src = 1'b1;
    evt_score = 1'b1;
    cyc();
    evt_score = 1'b0;
    check("retrig_half", 32'(dut.half_cnt), 32'd0);
    check("retrig_len", 32'(dut.len_cnt), 32'd0);
    check("retrig_audio", 32'(audio_out), 32'd1);

    // Mute mid-tone
    do_tick();
    check("pre_mute_audio", 32'(audio_out), 32'd1);
    mute = 1'b1;
    cyc();
    check("mute_audio", 32'(audio_out), 32'd0);
    check("mute_busy", 32'(busy), 32'd1);
    repeat (5) do_tick();
    check("mute_t6_audio", 32'(audio_out), 32'd0);
    check("mute_t6_busy", 32'(busy), 32'd1);
    mute = 1'b0;
    cyc();
    check("unmute_audio", 32'(audio_out), 32'd1);
    repeat (3) do_tick();
    check("score_t9_busy", 32'(busy), 32'd1);
    check("score_t9_audio", 32'(audio_out), 32'd0);
    do_tick();
    check("score_t10_busy", 32'(busy), 32'd0);
    check("score_t10_audio", 32'(audio_out), 32'd0);
    check("score_t10_state", 32'(dut.state), 32'(IDLE));

    // Reset mid-play with a paddle event on the same cycle
    evt_score = 1'b1;
    cyc();
    evt_score = 1'b0;
    do_tick(); do_tick();
    check("pre_rst_audio", 32'(audio_out), 32'd1);
    tick_src = 1'b0;
    cyc();
    tick_src = 1'b1;
    rst = 1'b1; evt_paddle = 1'b1;
    cyc();
    rst = 1'b0; evt_paddle = 1'b0;
    check("rst_mid_audio", 32'(audio_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_state", 32'(dut.state), 32'(IDLE));
    check("rst_mid_tone", 32'(dut.cur_tone), 32'(NONE));
    cyc();
    check("rst_drops_event", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
